// File: rtl/axi_wr_seq_pkg.sv
// ============================================================================
// Module      : axi_wr_seq_pkg
// Description : Shared types and AXI encodings for the write-burst sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi_wr_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } wr_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage : axi_wr_seq_pkg

`default_nettype wire

// File: rtl/axi_master_wr_sequencer.sv
// ============================================================================
// Module      : axi_master_wr_sequencer
// Description : Converts an (address, length) command plus a 32-bit beat
//               stream into one AXI4 INCR write burst. Optional B-channel
//               watchdog enabled by defining AXI_WR_SEQ_RESP_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_master_wr_sequencer
  import axi_wr_seq_pkg::*;
#(
  parameter int ID_WIDTH       = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [31:0]         cmd_addr,
  input  logic [7:0]          cmd_len,

  input  logic [31:0]         data_in,
  input  logic [3:0]          data_strb,
  input  logic                data_valid,
  output logic                data_ready,

  output logic                busy,
  output logic                err,
  input  logic                err_clr,

  output logic [ID_WIDTH-1:0] MASTER_WR_ADDR_ID,
  output logic [31:0]         MASTER_WR_ADDR,
  output logic [7:0]          MASTER_WR_ADDR_LEN,
  output logic [1:0]          MASTER_WR_ADDR_BURST,
  output logic                MASTER_WR_ADDR_VALID,
  input  logic                MASTER_WR_ADDR_READY,

  output logic [31:0]         MASTER_WR_DATA,
  output logic [3:0]          MASTER_WR_STRB,
  output logic                MASTER_WR_DATA_LAST,
  output logic                MASTER_WR_DATA_VALID,
  input  logic                MASTER_WR_DATA_READY,

  input  logic [ID_WIDTH-1:0] MASTER_WR_BACK_ID,
  input  logic [1:0]          MASTER_WR_BACK_RESP,
  input  logic                MASTER_WR_BACK_VALID,
  output logic                MASTER_WR_BACK_READY
);

  wr_state_e             state_q, state_d;
  logic [7:0]            beat_cnt_q, beat_cnt_d;
  logic [ID_WIDTH-1:0]   id_cnt_q, id_cnt_d;
  logic [31:0]           addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic                  err_q, err_d;
  logic                  err_set;
  logic                  resp_timeout;

`ifdef AXI_WR_SEQ_RESP_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Held at zero outside RESP so every response wait starts from a fresh count.
  always_comb begin
    to_cnt_d     = '0;
    resp_timeout = 1'b0;
    if (state_q == RESP) begin
      to_cnt_d     = to_cnt_q + 1'b1;
      resp_timeout = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end

  logic unused_in;
  assign unused_in = ^{MASTER_WR_BACK_ID, cmd_addr[1:0]};
`else
  assign resp_timeout = 1'b0;

  logic unused_in;
  assign unused_in = ^{MASTER_WR_BACK_ID, cmd_addr[1:0], (TIMEOUT_CYCLES > 0)};
`endif

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    id_cnt_d   = id_cnt_q;
    addr_d     = addr_q;
    len_d      = len_q;
    err_set    = 1'b0;

    cmd_ready            = 1'b0;
    busy                 = 1'b1;
    data_ready           = 1'b0;
    MASTER_WR_ADDR_BURST = 2'b00;
    MASTER_WR_ADDR_VALID = 1'b0;
    MASTER_WR_DATA       = '0;
    MASTER_WR_STRB       = '0;
    MASTER_WR_DATA_LAST  = 1'b0;
    MASTER_WR_DATA_VALID = 1'b0;
    MASTER_WR_BACK_READY = 1'b0;

    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          addr_d  = {cmd_addr[31:2], 2'b00};
          len_d   = cmd_len;
          state_d = ADDR;
        end
      end

      ADDR: begin
        MASTER_WR_ADDR_VALID = 1'b1;
        MASTER_WR_ADDR_BURST = AXI_BURST_INCR;
        if (MASTER_WR_ADDR_READY) begin
          state_d = DATA;
        end
      end

      DATA: begin
        MASTER_WR_DATA_VALID = data_valid;
        data_ready           = MASTER_WR_DATA_READY;
        MASTER_WR_DATA       = data_in;
        MASTER_WR_STRB       = data_strb;
        MASTER_WR_DATA_LAST  = (beat_cnt_q == len_q);
        if (data_valid && MASTER_WR_DATA_READY) begin
          if (beat_cnt_q == len_q) begin
            beat_cnt_d = '0;
            state_d    = RESP;
          end else begin
            beat_cnt_d = beat_cnt_q + 8'd1;
          end
        end
      end

      RESP: begin
        MASTER_WR_BACK_READY = 1'b1;
        if (MASTER_WR_BACK_VALID) begin
          err_set  = (MASTER_WR_BACK_RESP != AXI_RESP_OKAY);
          id_cnt_d = id_cnt_q + 1'b1;
          state_d  = IDLE;
        end else if (resp_timeout) begin
          err_set  = 1'b1;
          id_cnt_d = id_cnt_q + 1'b1;
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // A new error outranks a simultaneous clear so no failure is ever lost.
    if (err_set) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      id_cnt_q   <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      id_cnt_q   <= id_cnt_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      err_q      <= err_d;
    end
  end

  assign MASTER_WR_ADDR_ID  = id_cnt_q;
  assign MASTER_WR_ADDR     = addr_q;
  assign MASTER_WR_ADDR_LEN = len_q;
  assign err                = err_q;

endmodule : axi_master_wr_sequencer

`default_nettype wire

// File: tb/tb_axi_master_wr_sequencer.sv
// ============================================================================
// Module      : tb_axi_master_wr_sequencer
// Description : Directed self-checking bench for axi_master_wr_sequencer.
//               Timeout checks apply when AXI_WR_SEQ_RESP_TIMEOUT_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_master_wr_sequencer;

  localparam int IDW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [31:0]     cmd_addr;
  logic [7:0]      cmd_len;
  logic [31:0]     data_in;
  logic [3:0]      data_strb;
  logic            data_valid;
  logic            data_ready;
  logic            busy;
  logic            err;
  logic            err_clr;
  logic [IDW-1:0]  aw_id;
  logic [31:0]     aw_addr;
  logic [7:0]      aw_len;
  logic [1:0]      aw_burst;
  logic            aw_valid;
  logic            aw_ready;
  logic [31:0]     w_data;
  logic [3:0]      w_strb;
  logic            w_last;
  logic            w_valid;
  logic            w_ready;
  logic [IDW-1:0]  b_id;
  logic [1:0]      b_resp;
  logic            b_valid;
  logic            b_ready;

  int n_assert = 0;
  int n_fail   = 0;

  axi_master_wr_sequencer #(
    .ID_WIDTH       (IDW),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .cmd_valid            (cmd_valid),
    .cmd_ready            (cmd_ready),
    .cmd_addr             (cmd_addr),
    .cmd_len              (cmd_len),
    .data_in              (data_in),
    .data_strb            (data_strb),
    .data_valid           (data_valid),
    .data_ready           (data_ready),
    .busy                 (busy),
    .err                  (err),
    .err_clr              (err_clr),
    .MASTER_WR_ADDR_ID    (aw_id),
    .MASTER_WR_ADDR       (aw_addr),
    .MASTER_WR_ADDR_LEN   (aw_len),
    .MASTER_WR_ADDR_BURST (aw_burst),
    .MASTER_WR_ADDR_VALID (aw_valid),
    .MASTER_WR_ADDR_READY (aw_ready),
    .MASTER_WR_DATA       (w_data),
    .MASTER_WR_STRB       (w_strb),
    .MASTER_WR_DATA_LAST  (w_last),
    .MASTER_WR_DATA_VALID (w_valid),
    .MASTER_WR_DATA_READY (w_ready),
    .MASTER_WR_BACK_ID    (b_id),
    .MASTER_WR_BACK_RESP  (b_resp),
    .MASTER_WR_BACK_VALID (b_valid),
    .MASTER_WR_BACK_READY (b_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete burst; expected AW/W/B behaviour is derived from the arguments.
  task automatic run_txn(input logic [31:0] addr, input logic [7:0] len,
                         input logic [IDW-1:0] exp_id, input logic [1:0] resp,
                         input int aw_stall, input bit gaps, input int resp_wait);
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    logic [3:0]  exp_strb;
    int          beats;
    int          cyc;
    exp_addr  = {addr[31:2], 2'b00};
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_len   = len;
    #1;
    chk("cmd_ready_idle", cmd_ready, 1);
    chk("busy_idle", busy, 0);
    tick();
    cmd_valid  = 1'b0;
    cmd_addr   = 32'hFFFF_FFFF;
    cmd_len    = 8'hAA;
    data_valid = 1'b1;
    data_in    = 32'hBAD0_BAD0;
    w_ready    = 1'b1;
    #1;
    for (int i = 0; i < aw_stall; i++) begin
      chk("aw_valid_stall", aw_valid, 1);
      chk("aw_addr_stall", aw_addr, exp_addr);
      chk("aw_len_stall", aw_len, len);
      chk("aw_burst_stall", aw_burst, 2'b01);
      chk("aw_id_stall", aw_id, exp_id);
      chk("w_valid_before_aw", w_valid, 0);
      chk("data_ready_before_aw", data_ready, 0);
      chk("cmd_ready_busy", cmd_ready, 0);
      tick();
    end
    aw_ready = 1'b1;
    #1;
    chk("aw_valid", aw_valid, 1);
    chk("aw_addr", aw_addr, exp_addr);
    chk("aw_len", aw_len, len);
    chk("aw_burst", aw_burst, 2'b01);
    chk("aw_id", aw_id, exp_id);
    chk("w_valid_in_addr", w_valid, 0);
    chk("busy_addr", busy, 1);
    tick();
    aw_ready   = 1'b0;
    data_valid = 1'b0;
    w_ready    = 1'b0;
    beats      = 0;
    cyc        = 0;
    while (beats <= int'(len) && cyc < 400) begin
      data_valid = gaps ? ((cyc % 3) != 1) : 1'b1;
      w_ready    = gaps ? ((cyc % 4) != 2) : 1'b1;
      exp_data   = 32'hC0DE_0000 + exp_addr + 32'(beats);
      exp_strb   = 4'hF ^ 4'(beats);
      data_in    = exp_data;
      data_strb  = exp_strb;
      #1;
      chk("aw_valid_in_data", aw_valid, 0);
      chk("w_valid", w_valid, data_valid);
      chk("data_ready", data_ready, w_ready);
      chk("w_data", w_data, exp_data);
      chk("w_strb", w_strb, exp_strb);
      chk("w_last", w_last, (beats == int'(len)));
      if (data_valid && w_ready) beats++;
      cyc++;
      tick();
    end
    data_valid = 1'b0;
    w_ready    = 1'b0;
    chk("w_beat_count", beats, int'(len) + 1);
    for (int i = 0; i < resp_wait; i++) begin
      chk("b_ready_wait", b_ready, 1);
      chk("busy_resp", busy, 1);
      chk("w_valid_in_resp", w_valid, 0);
      tick();
    end
    b_valid = 1'b1;
    b_resp  = resp;
    b_id    = ~exp_id;
    #1;
    chk("b_ready", b_ready, 1);
    tick();
    b_valid = 1'b0;
    b_resp  = 2'b00;
    chk("busy_after_b", busy, 0);
    chk("cmd_ready_after_b", cmd_ready, 1);
  endtask

  initial begin
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_addr   = '0;
    cmd_len    = '0;
    data_in    = '0;
    data_strb  = '0;
    data_valid = 1'b0;
    err_clr    = 1'b0;
    aw_ready   = 1'b0;
    w_ready    = 1'b0;
    b_id       = '0;
    b_resp     = 2'b00;
    b_valid    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_aw_valid", aw_valid, 0);
    chk("rst_aw_addr", aw_addr, 0);
    chk("rst_aw_len", aw_len, 0);
    chk("rst_aw_id", aw_id, 0);
    chk("rst_aw_burst", aw_burst, 0);
    chk("rst_w_valid", w_valid, 0);
    chk("rst_w_last", w_last, 0);
    chk("rst_data_ready", data_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Single beat, always-ready slave
    run_txn(32'h0000_1000, 8'd0, 2'd0, 2'b00, 0, 1'b0, 1);
    chk("err_single", err, 0);
    // 16 beats with valid/ready gaps, issued back to back
    run_txn(32'h0000_2000, 8'd15, 2'd1, 2'b00, 0, 1'b1, 0);
    chk("err_burst16", err, 0);
    // AW stalled 10 cycles, unaligned start address
    run_txn(32'h0000_3006, 8'd3, 2'd2, 2'b00, 10, 1'b0, 2);
    chk("err_aw_stall", err, 0);
    // SLVERR response sets err
    run_txn(32'h0000_4000, 8'd1, 2'd3, 2'b10, 0, 1'b0, 0);
    chk("err_after_slverr", err, 1);
    // id wraps to 0; err stays sticky across an OKAY
    run_txn(32'h0000_5000, 8'd0, 2'd0, 2'b00, 0, 1'b0, 0);
    chk("err_sticky", err, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_cleared", err, 0);
    // Clear held during a DECERR: set must win
    err_clr = 1'b1;
    run_txn(32'h0000_6000, 8'd0, 2'd1, 2'b11, 0, 1'b0, 0);
    chk("err_set_wins", err, 1);
    tick();
    err_clr = 1'b0;
    chk("err_cleared_again", err, 0);

    // Reset in the middle of the data phase
    cmd_valid = 1'b1;
    cmd_addr  = 32'h0000_7000;
    cmd_len   = 8'd3;
    tick();
    cmd_valid = 1'b0;
    aw_ready  = 1'b1;
    tick();
    aw_ready   = 1'b0;
    data_valid = 1'b1;
    w_ready    = 1'b1;
    #1;
    chk("mid_w_valid", w_valid, 1);
    tick();
    chk("mid_w_last", w_last, 0);
    rst = 1'b1;
    #1;
    chk("rstmid_w_valid", w_valid, 0);
    chk("rstmid_aw_valid", aw_valid, 0);
    chk("rstmid_b_ready", b_ready, 0);
    chk("rstmid_data_ready", data_ready, 0);
    chk("rstmid_cmd_ready", cmd_ready, 1);
    chk("rstmid_busy", busy, 0);
    data_valid = 1'b0;
    w_ready    = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    // id counter restarts after reset
    run_txn(32'h0000_8000, 8'd2, 2'd0, 2'b00, 0, 1'b1, 0);

`ifdef AXI_WR_SEQ_RESP_TIMEOUT_EN
    cmd_valid = 1'b1;
    cmd_addr  = 32'h0000_9000;
    cmd_len   = 8'd0;
    tick();
    cmd_valid = 1'b0;
    aw_ready  = 1'b1;
    tick();
    aw_ready   = 1'b0;
    data_valid = 1'b1;
    w_ready    = 1'b1;
    tick();
    data_valid = 1'b0;
    w_ready    = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("to_b_ready", b_ready, 1);
      tick();
    end
    chk("to_busy", busy, 0);
    chk("to_err", err, 1);
    chk("to_cmd_ready", cmd_ready, 1);
    b_valid = 1'b1;
    #1;
    chk("late_b_ready", b_ready, 0);
    tick();
    b_valid = 1'b0;
    chk("late_b_busy", busy, 0);
    chk("late_b_err", err, 1);
`else
    // Without the watchdog the response wait is unbounded
    run_txn(32'h0000_9000, 8'd0, 2'd1, 2'b00, 0, 1'b0, 20);
    chk("long_wait_err", err, 0);
`endif
    run_txn(32'h0000_A000, 8'd0, 2'd2, 2'b00, 0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_axi_master_wr_sequencer

`default_nettype wire
